dcm_prog_ctrl: RTL and testbench
================================

# dcm_prog_ctrl

Configuration sequencer for the programmable clock divider. It turns user step/set requests into one-cycle `update` pulses with a 3-bit program code, and waits a fixed settle window. It then checks the divider's echoed code, retrying or flagging an error on mismatch. It sits between the board inputs (buttons/switches, already synchronised and edge-detected upstream) and the divider's `prog_in`/`update`/`prog_out` ports, on the same `clk`.

## Interface
Parameters:
- `SETTLE_CYCLES`, default 4: cycles spent in SETTLE after each update pulse; legal range 1..255.
- `MAX_RETRY`, default 2: extra update attempts after the first before flagging an error; legal range 0..7.

Ports:
- `clk`  in  1  single system clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `inc`  in  1  single-cycle request: target = `cur_sel` + 1, saturating at 7.
- `dec`  in  1  single-cycle request: target = `cur_sel` − 1, saturating at 0.
- `set`  in  1  single-cycle request: target = `set_val`.
- `set_val`  in  3  code loaded by `set`.
- `prog_ack`  in  3  code echoed by the divider (its `prog_out`).
- `prog_req`  out  3  code driven to the divider `prog_in`.
- `update`  out  1  one-cycle strobe to the divider.
- `busy`  out  1  high while a transaction is in flight.
- `err`  out  1  sticky failure flag.
- `cur_sel`  out  3  last confirmed code.

## Operation
- FSM states: IDLE, ISSUE, SETTLE, CHECK. Registered outputs only.
- **Reset values:** state IDLE, `prog_req` 0, `update` 0, `busy` 0, `err` 0, `cur_sel` 0, settle counter 0, retry counter 0. The divider also resets to code 0, so the two are in step.
- **IDLE:**
  - Request priority: `set` > `inc` > `dec`.
  - `inc` and `dec` together with no `set`: ignored.
  - A target equal to `cur_sel` while `err` = 0 is dropped: no transaction, no pulse.
  - When `err` = 1, any request (including one equal to `cur_sel`) is accepted.
  - An accepted request latches the target, clears `err`, clears the retry counter, and moves to ISSUE.
- **ISSUE:**
  - `update` = 1 for exactly this cycle; `prog_req` = target.
  - Load the settle counter with `SETTLE_CYCLES`, then go to SETTLE.
- **SETTLE:** decrement the counter; when it reaches 1, go to CHECK.
- **CHECK:**
  - `prog_ack` == target: `cur_sel` ← target, go to IDLE.
  - Else, if retry count < `MAX_RETRY`: increment the retry count, go to ISSUE.
  - Else: `err` ← 1, `cur_sel` unchanged, go to IDLE.
- `busy` = 1 in every state except IDLE.
- Requests arriving while `busy` = 1 are discarded, not queued.
- `prog_req` holds the last issued target after completion, including after an error.
- Arithmetic is 3-bit unsigned with explicit saturation; no wrap-around: 7 + 1 stays 7, 0 − 1 stays 0.

## Timing
- Edge E0 samples a request in IDLE.
- After E0: ISSUE, `update` = 1, `busy` = 1, `prog_req` = target.
- After E1: SETTLE, `update` = 0.
- After E(1+S): CHECK, where S = `SETTLE_CYCLES`.
- E(2+S) evaluates `prog_ack`. On success, `cur_sel` updates and `busy` = 0 are visible after E(2+S): 6 cycles for S = 4.
- Each retry adds S + 2 cycles. The worst-case transaction is (`MAX_RETRY` + 1)·(S + 2) cycles: 18 for the defaults.
- `prog_ack` is sampled only in CHECK; its value in other states is don't-care.
- `update` never asserts on two consecutive cycles. Consecutive update pulses are at least S + 2 cycles apart.
- A request in the same cycle the FSM returns to IDLE (busy still 1) is discarded. The first cycle that can accept a new request is the cycle after `busy` falls.
- `rst` asserted at any time, including mid-SETTLE: all outputs go to their reset values immediately, with no clock needed. `update` drops asynchronously. The first request is accepted at the first edge after `rst` deasserts.

## Test plan
- Reset: assert `rst` with `clk` stopped. Required: `prog_req` = 0, `update` = 0, `busy` = 0, `err` = 0, `cur_sel` = 0.
- Inc from 0, `prog_ack` tied to `prog_req`, defaults. Required: one `update` pulse with `prog_req` = 1; `busy` high for 6 cycles; `cur_sel` = 1.
- Saturation: `set` 7 completes, then pulse `inc`. Required: no `update`, `busy` stays 0, `cur_sel` = 7. Then `dec` at 0 after `set` 0: no pulse.
- Priority and busy: pulse `set` (`set_val` 5) with `inc` together. Required: target 5. Pulse `set` (`set_val` 2) while `busy`: ignored, final `cur_sel` = 5, exactly one `update` pulse.
- Failure: `prog_ack` stuck at 0, `set` 3, defaults. Required: 3 `update` pulses 6 cycles apart; then `err` = 1, `cur_sel` = 0, `busy` = 0. Then `set` 3 with a correct ack: `err` clears and `cur_sel` = 3.
- Async reset mid-op: assert `rst` two cycles into SETTLE. Required: outputs at reset values before the next edge. After release, `inc` completes to `cur_sel` = 1.

Source files
------------

// File: rtl/dcm_prog_if.sv
// Handshake bundle between the board-side request logic, the program
// sequencer and the clock divider's program port.
interface dcm_prog_if;
    logic       inc;
    logic       dec;
    logic       set;
    logic [2:0] set_val;
    logic [2:0] prog_ack;
    logic [2:0] prog_req;
    logic       update;
    logic       busy;
    logic       err;
    logic [2:0] cur_sel;

    modport master (
        output inc, dec, set, set_val, prog_ack,
        input  prog_req, update, busy, err, cur_sel
    );

    modport slave (
        input  inc, dec, set, set_val, prog_ack,
        output prog_req, update, busy, err, cur_sel
    );
endinterface

// File: rtl/dcm_prog_ctrl.sv
// Divider program sequencer: turns step/set requests into single update
// strobes, waits out the settle window, then verifies the echoed code.
module dcm_prog_ctrl #(
    parameter int SETTLE_CYCLES = 4,
    parameter int MAX_RETRY     = 2
) (
    input  logic       clk,
    input  logic       rst,
    dcm_prog_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, ISSUE, SETTLE, CHECK} state_t;

    localparam logic [7:0] SETTLE_LOAD = 8'(SETTLE_CYCLES);
    localparam logic [2:0] RETRY_LIM   = 3'(MAX_RETRY);

    state_t     state;
    logic [7:0] settle_cnt;
    logic [2:0] retry_cnt;
    logic [2:0] target;

    logic       req_valid;
    logic [2:0] req_target;

    // NOTE: every combinational output gets a default first so no path
    // leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        req_valid  = 1'b0;
        req_target = bus.cur_sel;
        if (bus.set) begin
            req_valid  = 1'b1;
            req_target = bus.set_val;
        end else if (bus.inc && !bus.dec) begin
            req_valid  = 1'b1;
            req_target = (bus.cur_sel == 3'd7) ? 3'd7 : bus.cur_sel + 3'd1;
        end else if (bus.dec && !bus.inc) begin
            req_valid  = 1'b1;
            req_target = (bus.cur_sel == 3'd0) ? 3'd0 : bus.cur_sel - 3'd1;
        end
    end

    // NOTE: state and outputs use non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            settle_cnt   <= 8'd0;
            retry_cnt    <= 3'd0;
            target       <= 3'd0;
            bus.prog_req <= 3'd0;
            bus.update   <= 1'b0;
            bus.busy     <= 1'b0;
            bus.err      <= 1'b0;
            bus.cur_sel  <= 3'd0;
        end else begin
            case (state)
                IDLE: begin
                    // A no-op target is only worth re-issuing to recover from an error.
                    if (req_valid && (req_target != bus.cur_sel || bus.err)) begin
                        target       <= req_target;
                        bus.err      <= 1'b0;
                        retry_cnt    <= 3'd0;
                        bus.prog_req <= req_target;
                        bus.update   <= 1'b1;
                        bus.busy     <= 1'b1;
                        state        <= ISSUE;
                    end
                end
                ISSUE: begin
                    bus.update <= 1'b0;
                    settle_cnt <= SETTLE_LOAD;
                    state      <= SETTLE;
                end
                SETTLE: begin
                    if (settle_cnt <= 8'd1) begin
                        state <= CHECK;
                    end
                    if (settle_cnt != 8'd0) begin
                        settle_cnt <= settle_cnt - 8'd1;
                    end
                end
                CHECK: begin
                    if (bus.prog_ack == target) begin
                        bus.cur_sel <= target;
                        bus.busy    <= 1'b0;
                        state       <= IDLE;
                    end else if (retry_cnt < RETRY_LIM) begin
                        retry_cnt    <= retry_cnt + 3'd1;
                        bus.prog_req <= target;
                        bus.update   <= 1'b1;
                        state        <= ISSUE;
                    end else begin
                        bus.err  <= 1'b1;
                        bus.busy <= 1'b0;
                        state    <= IDLE;
                    end
                end
                default: begin
                    bus.update <= 1'b0;
                    bus.busy   <= 1'b0;
                    state      <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_dcm_prog_ctrl.sv
// Bench for dcm_prog_ctrl: directed requests push expected update codes and
// completion results into queues that negedge monitors pop and compare.
module tb_dcm_prog_ctrl;
    localparam int S = 4;
    localparam int R = 2;

    typedef struct {
        logic [2:0] cur_sel;
        logic       err;
        int         busy_len;
    } comp_t;

    logic clk;
    logic rst;
    logic clk_en;
    logic ack_stuck;

    int n_checks;
    int n_fail;
    int pulse_cnt;
    int cycle;

    logic [2:0] exp_req_q[$];
    comp_t      exp_comp_q[$];

    dcm_prog_if bus ();

    dcm_prog_ctrl #(.SETTLE_CYCLES(S), .MAX_RETRY(R)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Divider model: echoes the programmed code, or is stuck at zero.
    always_comb bus.prog_ack = ack_stuck ? 3'd0 : bus.prog_req;

    initial begin
        clk = 1'b0;
        forever #5 clk = clk_en ? ~clk : clk;
    end

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Update-pulse monitor: checks code, and spacing of retry pulses.
    logic prev_busy;
    int   busy_len;
    int   last_pulse;
    always @(negedge clk) begin
        cycle++;
        if (rst) begin
            prev_busy = 1'b0;
            busy_len  = 0;
        end else begin
            if (bus.update) begin
                pulse_cnt++;
                if (exp_req_q.size() == 0) begin
                    check("unexpected_update", 1, 0);
                end else begin
                    check("update_prog_req", int'(bus.prog_req), int'(exp_req_q.pop_front()));
                end
                if (prev_busy) check("retry_gap", cycle - last_pulse, S + 2);
                last_pulse = cycle;
            end
            if (bus.busy) begin
                busy_len++;
            end else if (prev_busy) begin
                if (exp_comp_q.size() == 0) begin
                    check("unexpected_completion", 1, 0);
                end else begin
                    comp_t c;
                    c = exp_comp_q.pop_front();
                    check("done_cur_sel", int'(bus.cur_sel), int'(c.cur_sel));
                    check("done_err", int'(bus.err), int'(c.err));
                    check("done_busy_len", busy_len, c.busy_len);
                end
                busy_len = 0;
            end
            prev_busy = bus.busy;
        end
    end

    task automatic expect_txn(input logic [2:0] code, input int n_pulses,
                              input logic [2:0] fin_sel, input logic fin_err);
        comp_t c;
        for (int i = 0; i < n_pulses; i++) exp_req_q.push_back(code);
        c.cur_sel  = fin_sel;
        c.err      = fin_err;
        c.busy_len = n_pulses * (S + 2);
        exp_comp_q.push_back(c);
    endtask

    task automatic req(input logic i, input logic d, input logic s, input logic [2:0] v);
        @(posedge clk); #1;
        bus.inc = i; bus.dec = d; bus.set = s; bus.set_val = v;
        @(posedge clk); #1;
        bus.inc = 1'b0; bus.dec = 1'b0; bus.set = 1'b0;
    endtask

    task automatic wait_idle();
        bit done;
        done = 1'b0;
        for (int i = 0; i < 60 && !done; i++) begin
            if (!bus.busy) done = 1'b1;
            else begin
                @(posedge clk); #1;
            end
        end
        if (!done) check("busy_timeout", 1, 0);
        @(posedge clk); #1;
    endtask

    task automatic check_outputs_reset(input string tag);
        check({tag, "_prog_req"}, int'(bus.prog_req), 0);
        check({tag, "_update"},   int'(bus.update),   0);
        check({tag, "_busy"},     int'(bus.busy),     0);
        check({tag, "_err"},      int'(bus.err),      0);
        check({tag, "_cur_sel"},  int'(bus.cur_sel),  0);
    endtask

    int p0;

    initial begin
        n_checks = 0; n_fail = 0; pulse_cnt = 0; cycle = 0;
        prev_busy = 1'b0; busy_len = 0; last_pulse = 0;
        clk_en = 1'b0; ack_stuck = 1'b0; rst = 1'b0;
        bus.inc = 1'b0; bus.dec = 1'b0; bus.set = 1'b0; bus.set_val = 3'd0;

        // Reset with the clock stopped.
        #2 rst = 1'b1;
        #3 check_outputs_reset("reset");
        clk_en = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Inc from 0.
        p0 = pulse_cnt;
        expect_txn(3'd1, 1, 3'd1, 1'b0);
        req(1, 0, 0, 3'd0);
        wait_idle();
        check("inc_cur_sel", int'(bus.cur_sel), 1);
        check("inc_pulses", pulse_cnt - p0, 1);

        // Saturation at 7.
        expect_txn(3'd7, 1, 3'd7, 1'b0);
        req(0, 0, 1, 3'd7);
        wait_idle();
        p0 = pulse_cnt;
        req(1, 0, 0, 3'd0);
        check("sat_hi_busy", int'(bus.busy), 0);
        repeat (3) @(posedge clk); #1;
        check("sat_hi_pulses", pulse_cnt - p0, 0);
        check("sat_hi_cur_sel", int'(bus.cur_sel), 7);

        // Saturation at 0.
        expect_txn(3'd0, 1, 3'd0, 1'b0);
        req(0, 0, 1, 3'd0);
        wait_idle();
        p0 = pulse_cnt;
        req(0, 1, 0, 3'd0);
        check("sat_lo_busy", int'(bus.busy), 0);
        repeat (3) @(posedge clk); #1;
        check("sat_lo_pulses", pulse_cnt - p0, 0);
        check("sat_lo_cur_sel", int'(bus.cur_sel), 0);

        // Priority set > inc, and a set while busy is dropped.
        p0 = pulse_cnt;
        expect_txn(3'd5, 1, 3'd5, 1'b0);
        req(1, 0, 1, 3'd5);
        @(posedge clk); #1;
        req(0, 0, 1, 3'd2);
        wait_idle();
        check("prio_cur_sel", int'(bus.cur_sel), 5);
        check("prio_pulses", pulse_cnt - p0, 1);

        // Failure with a stuck ack, then recovery.
        expect_txn(3'd0, 1, 3'd0, 1'b0);
        req(0, 0, 1, 3'd0);
        wait_idle();
        ack_stuck = 1'b1;
        p0 = pulse_cnt;
        expect_txn(3'd3, R + 1, 3'd0, 1'b1);
        req(0, 0, 1, 3'd3);
        wait_idle();
        check("fail_pulses", pulse_cnt - p0, R + 1);
        check("fail_err", int'(bus.err), 1);
        check("fail_cur_sel", int'(bus.cur_sel), 0);
        check("fail_prog_req_hold", int'(bus.prog_req), 3);
        ack_stuck = 1'b0;
        expect_txn(3'd3, 1, 3'd3, 1'b0);
        req(0, 0, 1, 3'd3);
        wait_idle();
        check("recover_err", int'(bus.err), 0);
        check("recover_cur_sel", int'(bus.cur_sel), 3);

        // Async reset two cycles into SETTLE.
        exp_req_q.push_back(3'd4);
        req(1, 0, 0, 3'd0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        #1 check_outputs_reset("midop");
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        expect_txn(3'd1, 1, 3'd1, 1'b0);
        req(1, 0, 0, 3'd0);
        wait_idle();
        check("post_rst_cur_sel", int'(bus.cur_sel), 1);

        repeat (3) @(posedge clk); #1;
        check("req_queue_left", exp_req_q.size(), 0);
        check("comp_queue_left", exp_comp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: sim time %0t exceeded limit", $time);
        $fatal(1);
    end
endmodule
